burst_addr_decoder: RTL and testbench

BURST_ADDR_DECODER -- requirements
Module: burst_addr_decoder

---
 rtl/burst_addr_decoder.sv | 121 ++++++++++++
 tb/tb_burst_addr_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_addr_decoder.sv
// AXI-style burst address decoder: expands one FIXED/INCR/WRAP request into per-beat
// word/byte offsets inside a 2^(OffsetWidth+2)-byte window. WRAP support is built only with BURST_ADDR_DECODER_WRAP_EN.
module burst_addr_decoder #(
    parameter logic [31:0] BaseAddr    = 32'h0000_0000,
    parameter int          OffsetWidth = 6
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [31:0]            a_addr,
    input  logic [7:0]             a_len,
    input  logic [1:0]             a_burst,
    output logic                   b_valid,
    input  logic                   b_ready,
    output logic [OffsetWidth-1:0] word_offset,
    output logic [1:0]             byte_offset,
    output logic                   b_last,
    output logic                   b_error
);

    typedef enum logic {IDLE, BURST} state_e;
    localparam logic [1:0] FIXED = 2'd0;
    localparam logic [1:0] INCR  = 2'd1;
    localparam logic [1:0] WRAP  = 2'd2;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  len_q, len_d;
    logic [1:0]  mode_q, mode_d;
    logic        illegal_q, illegal_d;

    logic        accept, advance;
    logic        wrap_bad, req_illegal;
    logic [31:0] wrap_mask, next_addr;

    assign accept  = a_valid && (state_q == IDLE);
    assign advance = b_ready && (state_q == BURST);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            mode_q    <= FIXED;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BURST;
            BURST:   if (advance && cnt_q == 8'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Illegal bursts still walk an INCR sequence so the consumer sees every beat, all flagged.
    always_comb begin
`ifdef BURST_ADDR_DECODER_WRAP_EN
        wrap_bad = !(a_len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (a_addr[1:0] != 2'b00) ||
                   (({24'd0, a_len} + 32'd1) > (32'd1 << OffsetWidth));
`else
        wrap_bad = 1'b1;
`endif
        req_illegal = (a_burst == 2'd3) || ((a_burst == WRAP) && wrap_bad);
    end

    always_comb begin
        wrap_mask = {22'd0, len_q, 2'b11};
        case (mode_q)
            FIXED:   next_addr = addr_q;
            WRAP:    next_addr = (addr_q & ~wrap_mask) | ((addr_q + 32'd4) & wrap_mask);
            default: next_addr = (addr_q & ~32'd3) + 32'd4;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        mode_d    = mode_q;
        illegal_d = illegal_q;
        if (accept) begin
            addr_d    = a_addr;
            cnt_d     = a_len;
            len_d     = a_len;
            mode_d    = req_illegal ? INCR : a_burst;
            illegal_d = req_illegal;
        end else if (advance && cnt_q != 8'd0) begin
            addr_d = next_addr;
            cnt_d  = cnt_q - 8'd1;
        end
    end

    always_comb begin
        a_ready     = (state_q == IDLE);
        b_valid     = (state_q == BURST);
        word_offset = '0;
        byte_offset = '0;
        b_last      = 1'b0;
        b_error     = 1'b0;
        if (state_q == BURST) begin
            word_offset = addr_q[OffsetWidth+1:2];
            byte_offset = addr_q[1:0];
            b_last      = (cnt_q == 8'd0);
            b_error     = illegal_q || (addr_q[31:OffsetWidth+2] != BaseAddr[31:OffsetWidth+2]);
        end
    end

endmodule

// File: tb/tb_burst_addr_decoder.sv
// Directed-vector bench for burst_addr_decoder (BaseAddr=0, OffsetWidth=6).
module tb_burst_addr_decoder;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [31:0] a_addr = '0;
    logic [7:0] a_len = '0;
    logic [1:0] a_burst = '0;
    logic       b_valid;
    logic       b_ready = 1'b0;
    logic [5:0] word_offset;
    logic [1:0] byte_offset;
    logic       b_last;
    logic       b_error;

    int nvec = 0;
    int nerr = 0;

    burst_addr_decoder #(.BaseAddr(32'h0), .OffsetWidth(6)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_len(a_len), .a_burst(a_burst),
        .b_valid(b_valid), .b_ready(b_ready),
        .word_offset(word_offset), .byte_offset(byte_offset), .b_last(b_last), .b_error(b_error)
    );

    always #5 aclk = ~aclk;

    // Presents one request for a single cycle; on return the first beat is visible.
    task automatic send_req(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        @(negedge aclk);
        a_valid = 1'b1; a_addr = addr; a_len = len; a_burst = burst;
        @(negedge aclk);
        a_valid = 1'b0;
    endtask

    task automatic test_reset();
        nvec++;
        if ({a_ready, b_valid, b_last, b_error, word_offset, byte_offset} !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0}) begin
            nerr++;
            $display("FAIL reset_state got rdy=%b vld=%b last=%b err=%b wo=%0d bo=%0d want 1 0 0 0 0 0",
                     a_ready, b_valid, b_last, b_error, word_offset, byte_offset);
        end
    endtask

    task automatic test_incr_basic();
        logic [5:0] exp_wo [4] = '{6'd2, 6'd3, 6'd4, 6'd5};
        b_ready = 1'b1;
        send_req(32'h08, 8'd3, 2'd1);
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if ({b_valid, a_ready, word_offset, b_last, b_error} !== {1'b1, 1'b0, exp_wo[i], (i == 3), 1'b0}) begin
                nerr++;
                $display("FAIL incr_basic beat%0d got vld=%b rdy=%b wo=%0d last=%b err=%b want wo=%0d last=%b err=0",
                         i, b_valid, a_ready, word_offset, b_last, b_error, exp_wo[i], (i == 3));
            end
            @(negedge aclk);
        end
        nvec++;
        if ({a_ready, b_valid} !== 2'b10) begin
            nerr++;
            $display("FAIL incr_basic_idle got rdy=%b vld=%b want 1 0", a_ready, b_valid);
        end
    endtask

    task automatic test_incr_window_top();
        logic [5:0] exp_wo [4] = '{6'd62, 6'd63, 6'd0, 6'd1};
        logic       exp_er [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        b_ready = 1'b1;
        send_req(32'hF8, 8'd3, 2'd1);
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if ({b_valid, word_offset, b_error, b_last} !== {1'b1, exp_wo[i], exp_er[i], (i == 3)}) begin
                nerr++;
                $display("FAIL incr_top beat%0d got vld=%b wo=%0d err=%b last=%b want wo=%0d err=%b last=%b",
                         i, b_valid, word_offset, b_error, b_last, exp_wo[i], exp_er[i], (i == 3));
            end
            @(negedge aclk);
        end
    endtask

    task automatic test_wrap();
`ifdef BURST_ADDR_DECODER_WRAP_EN
        logic [5:0] exp_wo [4] = '{6'd6, 6'd7, 6'd4, 6'd5};
        logic       exp_er = 1'b0;
`else
        logic [5:0] exp_wo [4] = '{6'd6, 6'd7, 6'd8, 6'd9};
        logic       exp_er = 1'b1;
`endif
        logic [5:0] bad_wo [3] = '{6'd6, 6'd7, 6'd8};
        b_ready = 1'b1;
        send_req(32'h18, 8'd3, 2'd2);
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if ({b_valid, word_offset, b_error, b_last} !== {1'b1, exp_wo[i], exp_er, (i == 3)}) begin
                nerr++;
                $display("FAIL wrap_len3 beat%0d got vld=%b wo=%0d err=%b last=%b want wo=%0d err=%b last=%b",
                         i, b_valid, word_offset, b_error, b_last, exp_wo[i], exp_er, (i == 3));
            end
            @(negedge aclk);
        end
        send_req(32'h18, 8'd2, 2'd2);
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if ({b_valid, word_offset, b_error, b_last} !== {1'b1, bad_wo[i], 1'b1, (i == 2)}) begin
                nerr++;
                $display("FAIL wrap_len2 beat%0d got vld=%b wo=%0d err=%b last=%b want wo=%0d err=1 last=%b",
                         i, b_valid, word_offset, b_error, b_last, bad_wo[i], (i == 2));
            end
            @(negedge aclk);
        end
    endtask

    task automatic test_reserved_burst();
        b_ready = 1'b1;
        send_req(32'h0, 8'd1, 2'd3);
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if ({b_valid, word_offset, b_error, b_last} !== {1'b1, 6'(i), 1'b1, (i == 1)}) begin
                nerr++;
                $display("FAIL reserved beat%0d got vld=%b wo=%0d err=%b last=%b want wo=%0d err=1 last=%b",
                         i, b_valid, word_offset, b_error, b_last, i, (i == 1));
            end
            @(negedge aclk);
        end
    endtask

    task automatic test_fixed_stall();
        b_ready = 1'b0;
        send_req(32'h13, 8'd2, 2'd0);
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 2; s++) begin
                nvec++;
                if ({b_valid, word_offset, byte_offset, b_last, b_error} !== {1'b1, 6'd4, 2'd3, (i == 2), 1'b0}) begin
                    nerr++;
                    $display("FAIL fixed beat%0d/%0d got vld=%b wo=%0d bo=%0d last=%b err=%b want wo=4 bo=3 last=%b err=0",
                             i, s, b_valid, word_offset, byte_offset, b_last, b_error, (i == 2));
                end
                if (s == 0) @(negedge aclk);
            end
            b_ready = 1'b1;
            @(negedge aclk);
            b_ready = 1'b0;
        end
        nvec++;
        if ({a_ready, b_valid} !== 2'b10) begin
            nerr++;
            $display("FAIL fixed_idle got rdy=%b vld=%b want 1 0", a_ready, b_valid);
        end
    endtask

    task automatic test_single_beat();
        b_ready = 1'b1;
        send_req(32'h21, 8'd0, 2'd1);
        nvec++;
        if ({b_valid, word_offset, byte_offset, b_last, b_error} !== {1'b1, 6'd8, 2'd1, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL single got vld=%b wo=%0d bo=%0d last=%b err=%b want 1 8 1 1 0",
                     b_valid, word_offset, byte_offset, b_last, b_error);
        end
        @(negedge aclk);
        nvec++;
        if ({a_ready, b_valid} !== 2'b10) begin
            nerr++;
            $display("FAIL single_idle got rdy=%b vld=%b want 1 0", a_ready, b_valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        b_ready = 1'b1;
        send_req(32'h0, 8'd7, 2'd1);
        @(negedge aclk);
        nvec++;
        if ({b_valid, word_offset} !== {1'b1, 6'd1}) begin
            nerr++;
            $display("FAIL mid_beat1 got vld=%b wo=%0d want 1 1", b_valid, word_offset);
        end
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        nvec++;
        if ({b_valid, b_last, b_error, word_offset} !== {1'b0, 1'b0, 1'b0, 6'd0}) begin
            nerr++;
            $display("FAIL mid_reset got vld=%b last=%b err=%b wo=%0d want 0 0 0 0", b_valid, b_last, b_error, word_offset);
        end
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        nvec++;
        if ({a_ready, b_valid} !== 2'b10) begin
            nerr++;
            $display("FAIL mid_release got rdy=%b vld=%b want 1 0", a_ready, b_valid);
        end
        send_req(32'h20, 8'd1, 2'd1);
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if ({b_valid, word_offset, b_last, b_error} !== {1'b1, 6'(8 + i), (i == 1), 1'b0}) begin
                nerr++;
                $display("FAIL mid_next beat%0d got vld=%b wo=%0d last=%b err=%b want wo=%0d last=%b err=0",
                         i, b_valid, word_offset, b_last, b_error, 8 + i, (i == 1));
            end
            @(negedge aclk);
        end
    endtask

    initial begin
        #12;
        test_reset();
        aresetn = 1'b1;
        @(negedge aclk);
        test_reset();
        test_incr_basic();
        test_incr_window_top();
        test_wrap();
        test_reserved_burst();
        test_fixed_stall();
        test_single_beat();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
